// File: rtl/pipeif.sv
// rtl/pipeif.sv - instruction-fetch stage: PC, next-PC select and imem request/ready handshake
module pipeif #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        loaddepen,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] ins,
    output logic        fvalid
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] buf_q;
    logic [31:0] ptgt_q;
    logic        pend_q;

    logic        redirect_d;
    logic [31:0] tgt_d;
    logic [31:0] npc_d;

    // Redirects only count when IF/ID actually loads; targets are word aligned on entry.
    always_comb begin
        tgt_d = 32'h0;
        case (pcsource)
            2'b01:   tgt_d = bpc;
            2'b10:   tgt_d = rpc;
            2'b11:   tgt_d = jpc;
            default: tgt_d = 32'h0;
        endcase
        tgt_d      = {tgt_d[31:2], 2'b00};
        redirect_d = loaddepen && (pcsource != 2'b00);
        if (redirect_d) begin
            npc_d = tgt_d;
        end else if (pend_q) begin
            npc_d = ptgt_q;
        end else begin
            npc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            buf_q   <= 32'h0;
            ptgt_q  <= 32'h0;
            pend_q  <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        if (loaddepen) begin
                            pc_q   <= npc_d;
                            pend_q <= 1'b0;
                        end else begin
                            buf_q   <= imem_rdata;
                            state_q <= HOLD;
                        end
                    end else if (redirect_d) begin
                        // The waiting fetch is the delay slot; remember where to go after it.
                        pend_q <= 1'b1;
                        ptgt_q <= tgt_d;
                    end
                end
                HOLD: begin
                    if (loaddepen) begin
                        pc_q    <= npc_d;
                        pend_q  <= 1'b0;
                        state_q <= FETCH;
                    end
                end
            endcase
        end
    end

    assign imem_req  = clrn && (state_q == FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign pc4       = pc_q + 32'd4;

    always_comb begin
        ins    = 32'h0;
        fvalid = 1'b0;
        if (clrn) begin
            if (state_q == HOLD) begin
                ins    = buf_q;
                fvalid = 1'b1;
            end else if (imem_ready) begin
                ins    = imem_rdata;
                fvalid = 1'b1;
            end
        end
    end

endmodule

// File: doc/pipeif.md
# pipeif

Instruction-fetch stage of the five-stage pipeline. It sits directly upstream of the IF/ID pipeline register and owns the program counter and next-PC selection. It runs a request/ready handshake to a variable-latency instruction memory and produces the `pc4`/`ins` pair that IF/ID latches. It inserts NOP bubbles on memory wait states and honours load-use stalls and delayed-branch redirects without losing or duplicating instructions.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `clk`  in  1  pipeline clock, all state on rising edge.
- `clrn`  in  1  asynchronous active-low reset.
- `loaddepen`  in  1  1 = IF/ID loads this cycle; 0 = load-use stall, IF/ID holds.
- `pcsource`  in  2  from ID: 00 sequential, 01 branch `bpc`, 10 register `rpc`, 11 jump `jpc`.
- `bpc`, `rpc`, `jpc`  in  32 each  redirect targets from ID.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, equals `pc`.
- `imem_rdata`  in  32  instruction word, valid in the cycle `imem_ready`=1.
- `imem_ready`  in  1  memory completes the request this cycle (zero-wait allowed).
- `pc`  out  32  address of the instruction being fetched.
- `pc4`  out  32  `pc`+4, to IF/ID.
- `ins`  out  32  instruction to IF/ID; 32'h0 (NOP) when no valid fetch.
- `fvalid`  out  1  `ins` carries a real instruction.

## Operation
- State: `pc`, FSM {FETCH, HOLD}, `buf` (32), `pend` (1), `ptgt` (32).
- Redirect target `tgt` = mux(`pcsource`) of `bpc`/`rpc`/`jpc`. Bits [1:0] are forced to 00 on every load into `pc` or `ptgt`.
- `npc` priority: (`loaddepen` & `pcsource`≠00) → `tgt`; else `pend` → `ptgt`; else `pc`+4.
- A redirect is acted on only in cycles with `loaddepen`=1. It never cancels the in-flight fetch, which is the delay slot.
- FETCH: `imem_req`=1.
  - `imem_ready`=1 & `loaddepen`=1: `ins`=`imem_rdata`, `fvalid`=1. `pc`<=`npc`, `pend`<=0. Stay in FETCH.
  - `imem_ready`=1 & `loaddepen`=0: `ins`=`imem_rdata`, `fvalid`=1, which IF/ID ignores. `buf`<=`imem_rdata`. Go to HOLD; `pc` unchanged.
  - `imem_ready`=0: `ins`=0, `fvalid`=0. If `loaddepen`=1 & `pcsource`≠00, then `pend`<=1 and `ptgt`<=`tgt`.
- HOLD: `imem_req`=0, `ins`=`buf`, `fvalid`=1.
  - `loaddepen`=1: `pc`<=`npc`, `pend`<=0, go to FETCH.
  - Otherwise remain in HOLD.
- `pc4` = `pc`+4 combinationally, modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- A new redirect overrides a pending one.

## Timing
- Reset (`clrn`=0, asynchronous): `pc`=`RESET_PC`, FSM=FETCH, `pend`=0, `ptgt`=0, `buf`=0. Outputs: `imem_req`=0 (gated by `clrn`), `ins`=0, `fvalid`=0, `pc4`=`RESET_PC`+4.
- First request is issued in the first cycle after `clrn` deasserts.
- Reset mid-fetch abandons the outstanding request; the memory must accept `imem_req` dropping.
- Zero-wait memory with no stall: one instruction per cycle.
- N wait cycles produce N NOP bubbles into IF/ID.
- `imem_addr` stays stable while `imem_req`=1 until `imem_ready`.
- A stall of K cycles after a completed fetch holds `pc` for K cycles. The held instruction is presented exactly once, in the cycle `loaddepen` returns to 1.

## Test plan
- Reset with `RESET_PC`=0, zero-wait memory returning addr+32'h100, `loaddepen`=1 → `ins` = 0x100, 0x104, 0x108 on consecutive cycles; `pc4` = 4, 8, C; `fvalid`=1 every cycle.
- `imem_ready` low 3 cycles at `pc`=8 → `ins`=0 with `fvalid`=0 for 3 cycles, then the word for 8; `imem_addr`=8 throughout.
- Fetch of `pc`=C completes with `loaddepen`=0 for 2 cycles → `imem_req`=0, `ins` holds the word for C, `pc`=C. When `loaddepen`=1, `pc` becomes 10 with no duplicate or skipped fetch.
- `pcsource`=01, `bpc`=0x40 at `pc`=14, zero-wait → delay slot 14 delivered, next `pc`=0x40. Repeat with `jpc`=0x43 → `pc`=0x40.
- `pcsource`=10, `rpc`=0x80 for one cycle while the fetch at 14 waits 2 cycles → word for 14 delivered, then `pc`=0x80 with `pend` cleared.
- `clrn` pulsed low mid-wait → `pc`=`RESET_PC`, `imem_req`=0 during reset, `fvalid`=0, `pend`=0. Fetch restarts at `RESET_PC`.
